keypad_code_lock: RTL and testbench

- Sits directly downstream of the 4x4 keypad scanner.
- Consumes the scanner's column index and the debounced row bits, and turns scan results into one-shot key events with a 4-bit key code.
- Feeds those events into a PIN-entry state machine that drives unlock, error and lockout outputs for the top-level LEDs.

---
 rtl/keypad_code_lock.sv | 226 ++++++++++++++++++++++
 tb/tb_keypad_code_lock.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_lock.sv
`default_nettype none
// ============================================================================
// Module   : keypad_code_lock
// Purpose  : Turns 4x4 keypad scan results into one-shot key events and runs
//            a PIN-entry state machine that drives the unlock, error and
//            lockout indicators.
// Ports    : clk_i          system clock
//            rst_ni         asynchronous active-low reset
//            col_idx_i      column currently driven by the scanner
//            rows_i         debounced row bits for that column
//            key_valid_o    one-cycle pulse per new key press
//            key_code_o     code of the last detected key (held)
//            digit_count_o  digits currently buffered
//            unlock_o       high while the lock is open
//            error_o        one-cycle pulse on a failed check
//            locked_out_o   high during lockout
//            fail_count_o   consecutive failed checks
// Revision : 1.0 - initial release
// ============================================================================
module keypad_code_lock #(
  parameter int          CODE_LEN       = 4,
  parameter logic [15:0] SECRET         = 16'h1234,
  parameter int          UNLOCK_CYCLES  = 1000000,
  parameter int          LOCKOUT_CYCLES = 4000000,
  parameter int          MAX_FAILS      = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] col_idx_i,
  input  logic [3:0] rows_i,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  output logic [2:0] digit_count_o,
  output logic       unlock_o,
  output logic       error_o,
  output logic       locked_out_o,
  output logic [2:0] fail_count_o
);

  localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    CODE_LEN_C  = 3'(CODE_LEN);
  localparam logic [2:0]    FAILS_C     = 3'(MAX_FAILS);
  // Key codes indexed by {column, row}; nibble 0 is column 0 / row 0.
  localparam logic [63:0]   KEYMAP      = 64'hDCBA_F963_0852_E741;

  // --------------------------------------------------------------------------
  // Scan sampling and press detection
  // --------------------------------------------------------------------------
  logic [1:0]  col_q;
  logic [3:0]  row_q;
  logic [15:0] map_q, map_d;
  logic [3:0]  seen_q, seen_d;   // column has a trustworthy map entry
  logic        sampled_q;        // row_q holds a real sample (not reset value)
  logic        key_valid_q;
  logic [3:0]  key_code_q;

  logic        commit;
  logic        single_row;
  logic        press;
  logic [3:0]  old_entry;
  logic [1:0]  row_idx;
  logic [3:0]  code_d;

  assign commit     = (col_idx_i != col_q) && sampled_q;
  assign old_entry  = map_q[{col_q, 2'b00} +: 4];
  assign single_row = (row_q != 4'd0) && ((row_q & (row_q - 4'd1)) == 4'd0);
  // A column seen for the first time after reset only seeds the map, so keys
  // already held when reset is released stay silent until re-pressed.
  assign press      = commit && single_row && (old_entry == 4'd0) && seen_q[col_q];

  always_comb begin
    row_idx = 2'd3;
    case (row_q)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
  end

  assign code_d = KEYMAP[{col_q, row_idx, 2'b00} +: 4];

  always_comb begin
    map_d  = map_q;
    seen_d = seen_q;
    if (commit) begin
      map_d[{col_q, 2'b00} +: 4] = row_q;
      seen_d[col_q]              = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q       <= 2'd0;
      row_q       <= 4'd0;
      map_q       <= 16'd0;
      seen_q      <= 4'd0;
      sampled_q   <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      col_q       <= col_idx_i;
      row_q       <= rows_i;
      map_q       <= map_d;
      seen_q      <= seen_d;
      sampled_q   <= 1'b1;
      key_valid_q <= press;
      if (press) begin
        key_code_q <= code_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // PIN-entry state machine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
    S_FAIL    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_e;

  state_e         state_q;
  logic [15:0]    buf_q;
  logic [2:0]     digit_q;
  logic [2:0]     fail_q;
  logic [TW-1:0]  timer_q;
  logic           unlock_q;
  logic           error_q;
  logic           locked_q;
  logic           match;

  assign match = (digit_q == CODE_LEN_C) &&
                 (buf_q[4*CODE_LEN-1:0] == SECRET[4*CODE_LEN-1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_ENTRY;
      buf_q    <= 16'd0;
      digit_q  <= 3'd0;
      fail_q   <= 3'd0;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        S_ENTRY: begin
          if (key_valid_q) begin
            if (key_code_q <= 4'h9) begin
              // Digits beyond CODE_LEN are dropped rather than shifted in.
              if (digit_q < CODE_LEN_C) begin
                buf_q   <= {buf_q[11:0], key_code_q};
                digit_q <= digit_q + 3'd1;
              end
            end else if (key_code_q == 4'hE) begin
              buf_q   <= 16'd0;
              digit_q <= 3'd0;
            end else if (key_code_q == 4'hF) begin
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          buf_q   <= 16'd0;
          digit_q <= 3'd0;
          if (match) begin
            state_q  <= S_OPEN;
            unlock_q <= 1'b1;
            fail_q   <= 3'd0;
            timer_q  <= UNLOCK_LOAD;
          end else if (fail_q + 3'd1 == FAILS_C) begin
            state_q  <= S_LOCKOUT;
            locked_q <= 1'b1;
            fail_q   <= fail_q + 3'd1;
            timer_q  <= LOCK_LOAD;
          end else begin
            state_q <= S_FAIL;
            error_q <= 1'b1;
            fail_q  <= fail_q + 3'd1;
            timer_q <= '0;
          end
        end
        S_OPEN: begin
          if (timer_q == '0) begin
            state_q  <= S_ENTRY;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_FAIL: begin
          state_q <= S_ENTRY;
        end
        S_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q  <= S_ENTRY;
            locked_q <= 1'b0;
            fail_q   <= 3'd0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= S_ENTRY;
        end
      endcase
    end
  end

  assign key_valid_o   = key_valid_q;
  assign key_code_o    = key_code_q;
  assign digit_count_o = digit_q;
  assign unlock_o      = unlock_q;
  assign error_o       = error_q;
  assign locked_out_o  = locked_q;
  assign fail_count_o  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_code_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_code_lock
// Purpose  : Directed self-checking bench for keypad_code_lock, with a small
//            scanner model driving column/row patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_code_lock;

  localparam int UNLOCK_N = 8;
  localparam int LOCK_N   = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] col_idx = 2'd0;
  logic [3:0] rows    = 4'd0;
  logic       key_valid;
  logic [3:0] key_code;
  logic [2:0] digit_count;
  logic       unlock;
  logic       error;
  logic       locked_out;
  logic [2:0] fail_count;

  keypad_code_lock #(
    .CODE_LEN       (4),
    .SECRET         (16'h1234),
    .UNLOCK_CYCLES  (UNLOCK_N),
    .LOCKOUT_CYCLES (LOCK_N),
    .MAX_FAILS      (3)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .col_idx_i     (col_idx),
    .rows_i        (rows),
    .key_valid_o   (key_valid),
    .key_code_o    (key_code),
    .digit_count_o (digit_count),
    .unlock_o      (unlock),
    .error_o       (error),
    .locked_out_o  (locked_out),
    .fail_count_o  (fail_count)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   kv_n = 0, kv_cyc = 0, unl_n = 0, unl_rise = 0, err_n = 0, lk_n = 0;
  logic unl_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitors sampled on the falling edge.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      kv_n   <= kv_n + 1;
      kv_cyc <= cyc;
    end
    if (unlock === 1'b1) unl_n <= unl_n + 1;
    if (unlock === 1'b1 && unl_prev !== 1'b1) unl_rise <= cyc;
    unl_prev <= unlock;
    if (error === 1'b1) err_n <= err_n + 1;
    if (locked_out === 1'b1) lk_n <= lk_n + 1;
  end

  // One full scan; column tc sees rows tr, all others see no key.
  task automatic scan(input int tc, input logic [3:0] tr);
    for (int c = 0; c < 4; c++) begin
      col_idx = 2'(c);
      rows    = (c == tc) ? tr : 4'b0000;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code, input bit rel);
    int         c;
    logic [3:0] r;
    c = 0;
    r = 4'b0001;
    case (code)
      4'h1: begin c = 0; r = 4'b0001; end
      4'h4: begin c = 0; r = 4'b0010; end
      4'h7: begin c = 0; r = 4'b0100; end
      4'hE: begin c = 0; r = 4'b1000; end
      4'h2: begin c = 1; r = 4'b0001; end
      4'h5: begin c = 1; r = 4'b0010; end
      4'h8: begin c = 1; r = 4'b0100; end
      4'h0: begin c = 1; r = 4'b1000; end
      4'h3: begin c = 2; r = 4'b0001; end
      4'h6: begin c = 2; r = 4'b0010; end
      4'h9: begin c = 2; r = 4'b0100; end
      4'hF: begin c = 2; r = 4'b1000; end
      4'hA: begin c = 3; r = 4'b0001; end
      4'hB: begin c = 3; r = 4'b0010; end
      4'hC: begin c = 3; r = 4'b0100; end
      default: begin c = 3; r = 4'b1000; end
    endcase
    scan(c, r);
    if (rel) scan(-1, 4'b0000);
  endtask

  task automatic test_reset();
    int k0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({key_valid, key_code, digit_count, unlock, error, locked_out, fail_count} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {key_valid, key_code, digit_count, unlock, error, locked_out, fail_count});
    end
    // Key 5 held across reset release must stay silent.
    k0 = kv_n;
    rst_n = 1'b1;
    scan(1, 4'b0010);
    scan(1, 4'b0010);
    tests++;
    if (kv_n - k0 !== 0) begin
      fails++;
      $display("FAIL held_at_reset: got %0d pulses expected 0", kv_n - k0);
    end
    scan(-1, 4'b0000);
    press(4'h5, 1);
    tests++;
    if (kv_n - k0 !== 1 || key_code !== 4'h5) begin
      fails++;
      $display("FAIL repress_after_reset: got %0d pulses code %h expected 1 code 5", kv_n - k0, key_code);
    end
  endtask

  task automatic test_single_key();
    int k0;
    k0 = kv_n;
    scan(2, 4'b0010);
    scan(2, 4'b0010);
    tests++;
    if (kv_n - k0 !== 1 || key_code !== 4'h6) begin
      fails++;
      $display("FAIL held_key_once: got %0d pulses code %h expected 1 code 6", kv_n - k0, key_code);
    end
    scan(-1, 4'b0000);
    scan(2, 4'b0010);
    tests++;
    if (kv_n - k0 !== 2) begin
      fails++;
      $display("FAIL repress: got %0d pulses expected 2", kv_n - k0);
    end
    scan(-1, 4'b0000);
  endtask

  task automatic test_ghost();
    int k0;
    k0 = kv_n;
    scan(0, 4'b0011);
    tests++;
    if (kv_n - k0 !== 0) begin
      fails++;
      $display("FAIL ghost_reject: got %0d pulses expected 0", kv_n - k0);
    end
    // Map now holds 0011 for col0, so dropping to a single row is no press.
    scan(0, 4'b0001);
    tests++;
    if (kv_n - k0 !== 0) begin
      fails++;
      $display("FAIL ghost_map_update: got %0d pulses expected 0", kv_n - k0);
    end
    scan(-1, 4'b0000);
    scan(0, 4'b0100);
    tests++;
    if (kv_n - k0 !== 1 || key_code !== 4'h7) begin
      fails++;
      $display("FAIL press_7: got %0d pulses code %h expected 1 code 7", kv_n - k0, key_code);
    end
    scan(-1, 4'b0000);
  endtask

  task automatic test_unlock();
    int         u0;
    logic [3:0] pin [4];
    pin = '{4'h1, 4'h2, 4'h3, 4'h4};
    press(4'hE, 1);
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL star_clear: got %0d expected 0", digit_count);
    end
    for (int i = 0; i < 4; i++) begin
      press(pin[i], 1);
      tests++;
      if (digit_count !== 3'(i + 1)) begin
        fails++;
        $display("FAIL digit_step%0d: got %0d expected %0d", i, digit_count, i + 1);
      end
    end
    u0 = unl_n;
    press(4'hF, 1);
    scan(-1, 4'b0000);
    tests++;
    if (unl_n - u0 !== UNLOCK_N) begin
      fails++;
      $display("FAIL unlock_len: got %0d expected %0d", unl_n - u0, UNLOCK_N);
    end
    tests++;
    if (unl_rise - kv_cyc !== 2) begin
      fails++;
      $display("FAIL unlock_latency: got %0d expected 2", unl_rise - kv_cyc);
    end
    tests++;
    if (fail_count !== 3'd0 || digit_count !== 3'd0 || unlock !== 1'b0) begin
      fails++;
      $display("FAIL after_unlock: got fail %0d digits %0d unlock %b expected 0 0 0",
               fail_count, digit_count, unlock);
    end
  endtask

  task automatic test_fail();
    int         e0;
    logic [3:0] seq [5];
    seq = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6};
    e0 = err_n;
    for (int i = 0; i < 5; i++) press(seq[i], 1);
    tests++;
    if (digit_count !== 3'd4) begin
      fails++;
      $display("FAIL digit_overflow: got %0d expected 4", digit_count);
    end
    press(4'hF, 1);
    scan(-1, 4'b0000);
    tests++;
    if (err_n - e0 !== 1 || fail_count !== 3'd1 || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL first_fail: got err %0d fails %0d digits %0d expected 1 1 0",
               err_n - e0, fail_count, digit_count);
    end
    press(4'h9, 1);
    press(4'hE, 1);
    tests++;
    if (digit_count !== 3'd0) begin
      fails++;
      $display("FAIL star_after_9: got %0d expected 0", digit_count);
    end
    press(4'hF, 1);
    scan(-1, 4'b0000);
    tests++;
    if (err_n - e0 !== 2 || fail_count !== 3'd2) begin
      fails++;
      $display("FAIL second_fail: got err %0d fails %0d expected 2 2", err_n - e0, fail_count);
    end
  endtask

  task automatic test_lockout();
    int         l0, e0, k0, u0;
    logic [3:0] pin [5];
    pin = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF};
    l0 = lk_n;
    e0 = err_n;
    press(4'hF, 1);
    tests++;
    if (locked_out !== 1'b1 || fail_count !== 3'd3) begin
      fails++;
      $display("FAIL lockout_entry: got locked %b fails %0d expected 1 3", locked_out, fail_count);
    end
    k0 = kv_n;
    press(4'h1, 1);
    tests++;
    if (kv_n - k0 !== 1 || digit_count !== 3'd0) begin
      fails++;
      $display("FAIL key_in_lockout: got pulses %0d digits %0d expected 1 0", kv_n - k0, digit_count);
    end
    scan(-1, 4'b0000);
    scan(-1, 4'b0000);
    tests++;
    if (lk_n - l0 !== LOCK_N || locked_out !== 1'b0 || fail_count !== 3'd0 || err_n - e0 !== 0) begin
      fails++;
      $display("FAIL lockout_len: got len %0d locked %b fails %0d err %0d expected %0d 0 0 0",
               lk_n - l0, locked_out, fail_count, err_n - e0, LOCK_N);
    end
    u0 = unl_n;
    for (int i = 0; i < 5; i++) press(pin[i], 1);
    scan(-1, 4'b0000);
    tests++;
    if (unl_n - u0 !== UNLOCK_N) begin
      fails++;
      $display("FAIL unlock_after_lockout: got %0d expected %0d", unl_n - u0, UNLOCK_N);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] pin [5];
    pin = '{4'hE, 4'h1, 4'h2, 4'h3, 4'h4};
    // Reset in ENTRY with a failure recorded and two digits buffered.
    press(4'hF, 1);
    scan(-1, 4'b0000);
    press(4'h1, 1);
    press(4'h2, 1);
    tests++;
    if (digit_count !== 3'd2 || fail_count !== 3'd1) begin
      fails++;
      $display("FAIL pre_reset_state: got digits %0d fails %0d expected 2 1", digit_count, fail_count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (digit_count !== 3'd0 || fail_count !== 3'd0) begin
      fails++;
      $display("FAIL async_reset_entry: got digits %0d fails %0d expected 0 0", digit_count, fail_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    scan(-1, 4'b0000);
    // Reset while OPEN.
    for (int i = 0; i < 5; i++) press(pin[i], 1);
    press(4'hF, 0);
    for (int i = 0; i < 20 && unlock !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (unlock !== 1'b1) begin
      fails++;
      $display("FAIL open_timeout: got unlock %b expected 1", unlock);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (unlock !== 1'b0 || digit_count !== 3'd0 || fail_count !== 3'd0 || key_code !== 4'h0) begin
      fails++;
      $display("FAIL async_reset_open: got unlock %b digits %0d fails %0d code %h expected 0 0 0 0",
               unlock, digit_count, fail_count, key_code);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    scan(-1, 4'b0000);
    press(4'h1, 1);
    tests++;
    if (digit_count !== 3'd1 || unlock !== 1'b0) begin
      fails++;
      $display("FAIL entry_after_reset: got digits %0d unlock %b expected 1 0", digit_count, unlock);
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_ghost();
    test_unlock();
    test_fail();
    test_lockout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
